// File: rtl/geofence_pkg.sv
// Shared definitions for the geofence load interface: object geometry,
// tuple widths and the driver/core state encoding.
package geofence_pkg;

  localparam int N_ANT = 6;
  localparam int XW    = 10;
  localparam int RW    = 11;
  localparam int IDX_W = $clog2(N_ANT);
  localparam int TW    = 2 * XW + RW;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEND   = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } gf_state_e;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [RW-1:0] r;
  } gf_tuple_t;

  function automatic gf_tuple_t pack_tuple(input logic [XW-1:0] x,
                                           input logic [XW-1:0] y,
                                           input logic [RW-1:0] r);
    gf_tuple_t t;
    t.x = x;
    t.y = y;
    t.r = r;
    return t;
  endfunction

endpackage

// File: rtl/geofence_tuple_buf.sv
// One-object tuple store: N_ANT entries, one write port, one
// asynchronous read port. Contents are not reset; they are always
// rewritten in FILL before being read in SEND.
module geofence_tuple_buf
  import geofence_pkg::*;
#(
  parameter int DEPTH = N_ANT,
  parameter int AW    = IDX_W
) (
  input  logic      clk,
  input  logic      we,
  input  logic [AW-1:0] waddr,
  input  gf_tuple_t wdata,
  input  logic [AW-1:0] raddr,
  output gf_tuple_t rdata
);

  gf_tuple_t mem [DEPTH];

  // write the accepted tuple into its slot
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/geofence_stim_driver.sv
// Transmit side of the geofence load interface: buffers one object of
// N_ANT tuples, streams it gap-free to the core, waits for the verdict
// (or a timeout) and hands the result downstream on a valid/ready port.
//
//  state  | meaning
//  FILL   | accepting tuples from upstream into the buffer
//  SEND   | streaming buffer entries to the core, one per cycle
//  WAIT   | waiting for the core verdict, timer running
//  RESULT | holding the verdict until downstream takes it
module geofence_stim_driver
  import geofence_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter int          TOW      = 8,
  // completed-result counter start value; nonzero only for characterisation
  parameter logic [15:0] CNT_INIT = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [XW-1:0] in_y,
  input  logic [RW-1:0] in_r,
  output logic [XW-1:0] X,
  output logic [XW-1:0] Y,
  output logic [RW-1:0] R,
  input  logic          gf_valid,
  input  logic          gf_is_inside,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_inside,
  output logic          res_timeout,
  output logic [15:0]   obj_cnt
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ANT - 1);
  localparam logic [TOW-1:0]   TMO_LAST = TOW'(TIMEOUT - 1);

  gf_state_e        state;
  logic [IDX_W-1:0] idx;
  logic [TOW-1:0]   timer;
  logic             buf_we;
  gf_tuple_t        buf_wdata;
  gf_tuple_t        buf_rdata;

  assign buf_we    = (state == FILL) && in_valid && in_ready;
  assign buf_wdata = pack_tuple(in_x, in_y, in_r);

  geofence_tuple_buf #(
    .DEPTH (N_ANT),
    .AW    (IDX_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (buf_wdata),
    .raddr (idx),
    .rdata (buf_rdata)
  );

  // sequencing FSM with all outputs registered; X/Y/R default to zero
  // so only SEND cycles put a tuple on the core bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      idx         <= '0;
      timer       <= '0;
      in_ready    <= 1'b0;
      X           <= '0;
      Y           <= '0;
      R           <= '0;
      res_valid   <= 1'b0;
      res_inside  <= 1'b0;
      res_timeout <= 1'b0;
      obj_cnt     <= CNT_INIT;
    end else begin
      X <= '0;
      Y <= '0;
      R <= '0;
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            if (idx == IDX_LAST) begin
              idx      <= '0;
              in_ready <= 1'b0;
              state    <= SEND;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        SEND: begin
          X <= buf_rdata.x;
          Y <= buf_rdata.y;
          R <= buf_rdata.r;
          if (idx == IDX_LAST) begin
            idx   <= '0;
            timer <= '0;
            state <= WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        WAIT: begin
          // a core verdict in the last allowed cycle beats the timeout
          if (gf_valid) begin
            res_inside  <= gf_is_inside;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end else if (timer == TMO_LAST) begin
            res_inside  <= 1'b0;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= RESULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            obj_cnt   <= obj_cnt + 16'd1;
            res_valid <= 1'b0;
            timer     <= '0;
            in_ready  <= 1'b1;
            state     <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_geofence_stim_driver.sv
// Directed bench for geofence_stim_driver. A second instance with a
// preloaded result counter shares all inputs to exercise counter wrap.
module tb_geofence_stim_driver;
  import geofence_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [XW-1:0] in_x = '0;
  logic [XW-1:0] in_y = '0;
  logic [RW-1:0] in_r = '0;
  logic          gf_valid = 1'b0;
  logic          gf_is_inside = 1'b0;
  logic          res_ready = 1'b0;

  logic          in_ready, res_valid, res_inside, res_timeout;
  logic [XW-1:0] X, Y;
  logic [RW-1:0] R;
  logic [15:0]   obj_cnt;

  logic          w_in_ready, w_res_valid, w_res_inside, w_res_timeout;
  logic [XW-1:0] w_X, w_Y;
  logic [RW-1:0] w_R;
  logic [15:0]   w_obj_cnt;

  int total = 0;
  int bad   = 0;

  logic [XW-1:0] tx [N_ANT];
  logic [XW-1:0] ty [N_ANT];
  logic [RW-1:0] tr [N_ANT];

  geofence_stim_driver #(.TIMEOUT(8), .TOW(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .X(X), .Y(Y), .R(R),
    .gf_valid(gf_valid), .gf_is_inside(gf_is_inside), .res_valid(res_valid),
    .res_ready(res_ready), .res_inside(res_inside), .res_timeout(res_timeout),
    .obj_cnt(obj_cnt)
  );

  geofence_stim_driver #(.TIMEOUT(8), .TOW(8), .CNT_INIT(16'hFFFF)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_x(in_x), .in_y(in_y), .in_r(in_r), .X(w_X), .Y(w_Y), .R(w_R),
    .gf_valid(gf_valid), .gf_is_inside(gf_is_inside), .res_valid(w_res_valid),
    .res_ready(res_ready), .res_inside(w_res_inside), .res_timeout(w_res_timeout),
    .obj_cnt(w_obj_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int base);
    for (int k = 0; k < N_ANT; k++) begin
      tx[k] = XW'(base + 10 * k);
      ty[k] = XW'(base + 10 * k + 10);
      tr[k] = RW'(base + 10 * k - 5);
    end
  endtask

  task automatic feed(input bit toggle);
    for (int k = 0; k < N_ANT; k++) begin
      in_valid = 1'b1;
      in_x = tx[k];
      in_y = ty[k];
      in_r = tr[k];
      tick();
      if (toggle && k < N_ANT - 1) begin
        in_valid = 1'b0;
        in_x = 10'h3FF;
        in_y = 10'h3FF;
        in_r = 11'h7FF;
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_send(input string tag);
    for (int k = 0; k < N_ANT; k++) begin
      tick();
      chk({tag, "_x"}, 32'(X), 32'(tx[k]));
      chk({tag, "_y"}, 32'(Y), 32'(ty[k]));
      chk({tag, "_r"}, 32'(R), 32'(tr[k]));
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_in;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_x", 32'(X), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_inside", 32'(res_inside), 32'd0);
    chk("rst_res_timeout", 32'(res_timeout), 32'd0);
    chk("rst_obj_cnt", 32'(obj_cnt), 32'd0);
    reset = 1'b1;
    tick();
    chk("fill_in_ready", 32'(in_ready), 32'd1);

    // object 1: contiguous feed, verdict inside on the 3rd WAIT cycle
    set_obj(10);
    feed(1'b0);
    chk("t1_ready_drop", 32'(in_ready), 32'd0);
    chk("t1_pre_x", 32'(X), 32'd0);
    chk_send("t1");
    tick();
    chk("t1_post_x", 32'(X), 32'd0);
    chk("t1_post_y", 32'(Y), 32'd0);
    chk("t1_post_r", 32'(R), 32'd0);
    tick();
    gf_valid = 1'b1;
    gf_is_inside = 1'b1;
    tick();
    chk("t3_res_valid", 32'(res_valid), 32'd1);
    chk("t3_res_inside", 32'(res_inside), 32'd1);
    chk("t3_res_timeout", 32'(res_timeout), 32'd0);
    for (int i = 0; i < 4; i++) begin
      gf_valid = 1'b1;
      gf_is_inside = 1'b0;
      tick();
      chk("t3_hold_valid", 32'(res_valid), 32'd1);
      chk("t3_hold_inside", 32'(res_inside), 32'd1);
      chk("t3_hold_timeout", 32'(res_timeout), 32'd0);
      chk("t3_hold_cnt", 32'(obj_cnt), 32'd0);
    end
    gf_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t3_hs_valid", 32'(res_valid), 32'd0);
    chk("t3_hs_cnt", 32'(obj_cnt), 32'd1);
    chk("t3_hs_wcnt", 32'(w_obj_cnt), 32'd0);
    chk("t3_hs_ready", 32'(in_ready), 32'd1);

    // object 2: toggling in_valid, then a timeout
    set_obj(100);
    feed(1'b1);
    chk("t2_ready_drop", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_x = 10'h155;
    in_y = 10'h2AA;
    in_r = 11'h555;
    chk_send("t2");
    in_valid = 1'b0;
    tick();
    chk("t2_post_x", 32'(X), 32'd0);
    chk("t4_wait_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4_wait_valid", 32'(res_valid), 32'd0);
    end
    tick();
    chk("t4_to_valid", 32'(res_valid), 32'd1);
    chk("t4_to_timeout", 32'(res_timeout), 32'd1);
    chk("t4_to_inside", 32'(res_inside), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4_to_cnt", 32'(obj_cnt), 32'd2);
    chk("t4_to_wcnt", 32'(w_obj_cnt), 32'd1);

    // object 3: verdict lands in the last allowed WAIT cycle
    set_obj(200);
    feed(1'b0);
    chk_send("t4b");
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4b_wait_valid", 32'(res_valid), 32'd0);
    end
    gf_valid = 1'b1;
    gf_is_inside = 1'b1;
    tick();
    gf_valid = 1'b0;
    gf_is_inside = 1'b0;
    chk("t4b_valid", 32'(res_valid), 32'd1);
    chk("t4b_timeout", 32'(res_timeout), 32'd0);
    chk("t4b_inside", 32'(res_inside), 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("t4b_cnt", 32'(obj_cnt), 32'd3);

    // reset during the 3rd SEND cycle
    set_obj(300);
    feed(1'b0);
    tick();
    tick();
    chk("t5_send_x", 32'(X), 32'(tx[1]));
    reset = 1'b0;
    #1;
    chk("t5_rst_x", 32'(X), 32'd0);
    chk("t5_rst_y", 32'(Y), 32'd0);
    chk("t5_rst_r", 32'(R), 32'd0);
    chk("t5_rst_valid", 32'(res_valid), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b1;
    gf_valid = 1'b1;
    gf_is_inside = 1'b1;
    tick();
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_valid", 32'(res_valid), 32'd0);
    chk("t5_cnt", 32'(obj_cnt), 32'd0);
    chk("t5_wcnt", 32'(w_obj_cnt), 32'hFFFF);
    tick();
    chk("t5_spur_valid", 32'(res_valid), 32'd0);
    chk("t5_spur_ready", 32'(in_ready), 32'd1);
    gf_valid = 1'b0;
    gf_is_inside = 1'b0;

    // three back-to-back objects at minimum period
    res_ready = 1'b1;
    for (int o = 0; o < 3; o++) begin
      exp_in = (o % 2 == 0);
      set_obj(400 + 100 * o);
      feed(1'b0);
      chk("t6_ready_drop", 32'(in_ready), 32'd0);
      chk_send("t6");
      gf_valid = 1'b1;
      gf_is_inside = exp_in;
      tick();
      gf_valid = 1'b0;
      gf_is_inside = 1'b0;
      chk("t6_valid", 32'(res_valid), 32'd1);
      chk("t6_inside", 32'(res_inside), 32'(exp_in));
      chk("t6_timeout", 32'(res_timeout), 32'd0);
      chk("t6_x_zero", 32'(X), 32'd0);
      tick();
      chk("t6_hs_valid", 32'(res_valid), 32'd0);
      chk("t6_cnt", 32'(obj_cnt), 32'(o + 1));
      chk("t6_wcnt", 32'(w_obj_cnt), 32'(o));
      chk("t6_ready", 32'(in_ready), 32'd1);
    end
    res_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
